// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Consumes a little-endian byte
//               stream (length, payload words, checksum) over valid/ready,
//               writes each assembled word into the instruction memory and
//               flags completion or failure.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 2048,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            byte_ready_o,
    output logic            we_o,
    output logic [AW-1:0]   waddr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            boot_done_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

    state_t          state_q;
    state_t          state_d;
    logic            armed_q;
    logic [31:0]     len_q;
    logic [7:0]      sum_q;
    logic [1:0]      byte_cnt_q;
    logic [AW-1:0]   word_idx_q;
    logic [XLEN-1:0] word_q;

    logic            accept;
    logic            last_byte;
    logic            last_word;
    logic            write_fire;
    logic [31:0]     len_next;
    logic [XLEN-1:0] word_next;
    logic [7:0]      sum_next;

    // Ready only once armed after reset and only in the collecting states;
    // terminal states ignore the stream entirely.
    assign byte_ready_o = armed_q &&
                          ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM));
    assign accept       = byte_valid_i && byte_ready_o;
    assign last_byte    = (byte_cnt_q == 2'd3);

    // Bytes arrive LSB first, so shifting each new byte in at the top leaves
    // byte 0 in bits [7:0] once four bytes have been taken.
    assign len_next  = {byte_data_i, len_q[31:8]};
    assign word_next = {byte_data_i, word_q[XLEN-1:8]};
    assign sum_next  = sum_q + byte_data_i;

    // len_q is at least 1 whenever this is consulted in S_DATA.
    assign last_word = ({{(32-AW){1'b0}}, word_idx_q} == (len_q - 32'd1));

    assign boot_done_o = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and write request.
    always_comb begin
        state_d    = state_q;
        write_fire = 1'b0;
        case (state_q)
            S_LEN: begin
                if (accept && last_byte) begin
                    if (len_next > MEM_SIZE_W) begin
                        state_d = S_ERR;
                    end else if (len_next == 32'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte) begin
                    write_fire = 1'b1;
                    if (last_word) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (byte_data_i == sum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Datapath: length capture, word assembly, checksum and registered write port.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            armed_q    <= 1'b0;
            len_q      <= 32'd0;
            sum_q      <= 8'd0;
            byte_cnt_q <= 2'd0;
            word_idx_q <= '0;
            word_q     <= '0;
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
        end else begin
            armed_q <= 1'b1;
            we_o    <= write_fire;
            if (write_fire) begin
                waddr_o <= word_idx_q;
                wdata_o <= word_next;
                // Hold the index on the final word so it never passes MEM_SIZE-1.
                if (!last_word) begin
                    word_idx_q <= word_idx_q + 1'b1;
                end
            end
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (state_q == S_LEN) begin
                    len_q <= len_next;
                end
                if (state_q == S_DATA) begin
                    word_q <= word_next;
                    sum_q  <= sum_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected imem writes are
//               queued as stimulus is driven and matched against write pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int XLEN     = 32;
    localparam int MEM_SIZE = 2048;
    localparam int AW       = $clog2(MEM_SIZE);

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = 8'd0;
    logic            byte_ready;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            boot_done;
    logic            err;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0]   exp_addr_q[$];
    logic [XLEN-1:0] exp_data_q[$];
    logic            prev_we = 1'b0;

    imem_loader #(.XLEN(XLEN), .MEM_SIZE(MEM_SIZE)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .boot_done_o  (boot_done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        check("done_err_exclusive", {63'd0, boot_done & err}, 64'd0);
        if (we) begin
            check("we_single_cycle", {63'd0, prev_we}, 64'd0);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", {63'd0, we}, 64'd0);
            end else begin
                check("waddr", {{(64-AW){1'b0}}, waddr}, {{(64-AW){1'b0}}, exp_addr_q.pop_front()});
                check("wdata", {32'd0, wdata}, {32'd0, exp_data_q.pop_front()});
            end
        end
        prev_we = we;
    end

    task automatic push_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Reset, check reset values while held, then release.
    task automatic do_reset();
        byte_valid = 1'b0;
        rstn       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    {63'd0, we}, 64'd0);
        check("rst_waddr", {{(64-AW){1'b0}}, waddr}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);
        check("rst_done",  {63'd0, boot_done}, 64'd0);
        check("rst_err",   {63'd0, err}, 64'd0);
        check("rst_ready", {63'd0, byte_ready}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("armed_ready", {63'd0, byte_ready}, 64'd1);
    endtask

    // Present one byte after an optional random gap; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        while (!byte_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!byte_ready) begin
            check("accept_timeout", {63'd0, byte_ready}, 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[i*8 +: 8], max_gap);
        end
    endtask

    // Sends one word LSB first and queues its expected write before the final byte.
    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_write(a, w);
            send_byte(w[i*8 +: 8], max_gap);
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check(tag, 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic normal_load(input logic [7:0] csum, input int max_gap);
        send_len(32'd2, max_gap);
        send_word(0, 32'h0000_0013, max_gap);
        send_word(1, 32'h0010_0093, max_gap);
        send_byte(csum, max_gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal 2-word load.
        do_reset();
        normal_load(8'hB6, 0);
        check("normal_done",  {63'd0, boot_done}, 64'd1);
        check("normal_err",   {63'd0, err}, 64'd0);
        check("normal_ready", {63'd0, byte_ready}, 64'd0);
        drain("normal_writes_left");

        // Bad checksum: writes still happen, then sticky error and no more accepts.
        do_reset();
        normal_load(8'hB5, 0);
        check("badsum_err",  {63'd0, err}, 64'd1);
        check("badsum_done", {63'd0, boot_done}, 64'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h13;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("badsum_ready", {63'd0, byte_ready}, 64'd0);
        end
        byte_valid = 1'b0;
        check("badsum_err_sticky", {63'd0, err}, 64'd1);
        drain("badsum_writes_left");

        // Empty program.
        do_reset();
        send_len(32'd0, 0);
        check("empty_not_done_yet", {63'd0, boot_done}, 64'd0);
        send_byte(8'h00, 0);
        check("empty_done", {63'd0, boot_done}, 64'd1);
        check("empty_err",  {63'd0, err}, 64'd0);
        drain("empty_writes_left");

        // Oversize length (2049) errors right after the 4th byte.
        do_reset();
        send_len(32'd2049, 0);
        check("oversize_err",   {63'd0, err}, 64'd1);
        check("oversize_ready", {63'd0, byte_ready}, 64'd0);
        check("oversize_done",  {63'd0, boot_done}, 64'd0);
        drain("oversize_writes_left");

        // Exactly MEM_SIZE is legal: first word then a wrong length-boundary probe is not needed,
        // just confirm the loader moved on to payload rather than erroring.
        do_reset();
        send_len(32'd2048, 0);
        check("maxlen_no_err", {63'd0, err}, 64'd0);
        check("maxlen_ready",  {63'd0, byte_ready}, 64'd1);

        // Checksum wrap: 4 x FF sums to 0x3FC -> FC.
        do_reset();
        send_len(32'd1, 0);
        send_word(0, 32'hFFFF_FFFF, 0);
        send_byte(8'hFC, 0);
        check("wrap_done", {63'd0, boot_done}, 64'd1);
        check("wrap_err",  {63'd0, err}, 64'd0);
        drain("wrap_writes_left");

        // Normal load with random valid gaps.
        do_reset();
        normal_load(8'hB6, 3);
        check("gap_done", {63'd0, boot_done}, 64'd1);
        drain("gap_writes_left");

        // Reset after two payload bytes, then a clean reload.
        do_reset();
        send_len(32'd2, 2);
        send_byte(8'h13, 2);
        send_byte(8'h00, 2);
        rstn = 1'b0;
        #1;
        check("midrst_we",    {63'd0, we}, 64'd0);
        check("midrst_waddr", {{(64-AW){1'b0}}, waddr}, 64'd0);
        check("midrst_wdata", {32'd0, wdata}, 64'd0);
        check("midrst_done",  {63'd0, boot_done}, 64'd0);
        check("midrst_err",   {63'd0, err}, 64'd0);
        check("midrst_ready", {63'd0, byte_ready}, 64'd0);
        do_reset();
        normal_load(8'hB6, 3);
        check("reload_done", {63'd0, boot_done}, 64'd1);
        check("reload_err",  {63'd0, err}, 64'd0);
        drain("reload_writes_left");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
